// File: rtl/text_terminal_pkg.sv
// Shared constants, control codes and FSM encoding for the character-cell text terminal.
package text_terminal_pkg;

    localparam int         COLS  = 16;
    localparam int         ROWS  = 8;
    localparam logic [7:0] BLANK = 8'h20;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_SCROLL = 2'd2
    } state_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_terminal_ram.sv
// Character store: one synchronous write port, one registered read port (old data on collision).
module text_ram #(
    parameter int         DEPTH   = 128,
    parameter int         AW      = 7,
    parameter int         DW      = 8,
    parameter logic [7:0] RST_VAL = 8'h20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset; the array itself stays reset-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_reg <= DW'(RST_VAL);
        end else begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/text_terminal.sv
// Text terminal: byte-stream decoder, cursor, hardware scroll via a rotating top-row offset.
module text_terminal
    import text_terminal_pkg::*;
#(
    parameter int         COLS  = text_terminal_pkg::COLS,
    parameter int         ROWS  = text_terminal_pkg::ROWS,
    parameter logic [7:0] BLANK = text_terminal_pkg::BLANK
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          in_ready,
    input  logic [$clog2(ROWS*COLS)-1:0]  rd_idx,
    output logic [7:0]                    rd_char,
    output logic [$clog2(ROWS)-1:0]       cur_row,
    output logic [$clog2(COLS)-1:0]       cur_col
);

    localparam int COL_W  = $clog2(COLS);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int ADDR_W = $clog2(ROWS*COLS);
    localparam int CELLS  = ROWS * COLS;

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  cnt_reg, cnt_next;
    logic [ROW_W-1:0]   row_reg, row_next;
    logic [COL_W-1:0]   col_reg, col_next;
    logic [ROW_W-1:0]   top_reg, top_next;
    logic [ROW_W-1:0]   srow_reg, srow_next;

    logic               accept;
    logic               printable;
    logic               newline;
    logic [COL_W-1:0]   col_dec;
    logic [ROW_W-1:0]   cur_phys_row;
    logic [ROW_W-1:0]   rd_phys_row;

    logic               we;
    logic [ADDR_W-1:0]  waddr;
    logic [7:0]         wdata;

    assign accept       = in_valid && (state_reg == ST_IDLE);
    assign printable    = is_printable(in_data);
    assign newline      = accept && ((printable && (col_reg == COL_W'(COLS-1))) || (in_data == CH_LF));
    assign col_dec      = col_reg - 1'b1;
    assign cur_phys_row = row_reg + top_reg;
    assign rd_phys_row  = rd_idx[ADDR_W-1:COL_W] + top_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_CLEAR;
            cnt_reg   <= '0;
            row_reg   <= '0;
            col_reg   <= '0;
            top_reg   <= '0;
            srow_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            row_reg   <= row_next;
            col_reg   <= col_next;
            top_reg   <= top_next;
            srow_reg  <= srow_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        row_next   = row_reg;
        col_next   = col_reg;
        top_next   = top_reg;
        srow_next  = srow_reg;
        unique case (state_reg)
            ST_CLEAR: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == ADDR_W'(CELLS-1)) begin
                    state_next = ST_IDLE;
                    row_next   = '0;
                    col_next   = '0;
                    top_next   = '0;
                end
            end
            ST_SCROLL: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg[COL_W-1:0] == COL_W'(COLS-1)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    if (printable) begin
                        col_next = col_reg + 1'b1;
                    end else if (in_data == CH_CR) begin
                        col_next = '0;
                    end else if ((in_data == CH_BS) && (col_reg != '0)) begin
                        col_next = col_dec;
                    end else if (in_data == CH_FF) begin
                        state_next = ST_CLEAR;
                        cnt_next   = '0;
                    end
                    // Scrolling only moves the top offset; the old top row becomes the new bottom row.
                    if (newline) begin
                        col_next = '0;
                        if (row_reg != ROW_W'(ROWS-1)) begin
                            row_next = row_reg + 1'b1;
                        end else begin
                            top_next   = top_reg + 1'b1;
                            srow_next  = top_reg;
                            state_next = ST_SCROLL;
                            cnt_next   = '0;
                        end
                    end
                end
            end
            default: begin
                state_next = ST_CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        in_ready = (state_reg == ST_IDLE);
        we       = 1'b0;
        waddr    = {cur_phys_row, col_reg};
        wdata    = in_data;
        unique case (state_reg)
            ST_CLEAR: begin
                we    = 1'b1;
                waddr = cnt_reg;
                wdata = BLANK;
            end
            ST_SCROLL: begin
                we    = 1'b1;
                waddr = {srow_reg, cnt_reg[COL_W-1:0]};
                wdata = BLANK;
            end
            ST_IDLE: begin
                if (accept && printable) begin
                    we = 1'b1;
                end else if (accept && (in_data == CH_BS) && (col_reg != '0)) begin
                    we    = 1'b1;
                    waddr = {cur_phys_row, col_dec};
                    wdata = BLANK;
                end
            end
            default: begin
                we = 1'b0;
            end
        endcase
    end

    text_ram #(
        .DEPTH   (CELLS),
        .AW      (ADDR_W),
        .DW      (8),
        .RST_VAL (BLANK)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr ({rd_phys_row, rd_idx[COL_W-1:0]}),
        .rdata (rd_char)
    );

    assign cur_row = row_reg;
    assign cur_col = col_reg;

endmodule

// File: tb/tb_text_terminal.sv
// Bench for text_terminal: logical-screen reference model, per-cycle compare, directed and random bytes.
module tb_text_terminal;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic [6:0] rd_idx = 7'd0;
    logic [7:0] rd_char;
    logic [2:0] cur_row;
    logic [3:0] cur_col;

    int passes = 0;
    int checks = 0;

    text_terminal dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .rd_idx   (rd_idx),
        .rd_char  (rd_char),
        .cur_row  (cur_row),
        .cur_col  (cur_col)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model: the screen as the viewer sees it, row 0 at the top.
    logic [7:0] scr [8][16];
    int         m_row, m_col, busy;
    bit         have_exp, prev_rst;
    logic [7:0] exp_char;

    function automatic void m_clear();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++) scr[r][c] = 8'h20;
        m_row = 0;
        m_col = 0;
    endfunction

    function automatic void m_newline();
        m_col = 0;
        if (m_row < 7) m_row++;
        else begin
            for (int r = 0; r < 7; r++) scr[r] = scr[r+1];
            for (int c = 0; c < 16; c++) scr[7][c] = 8'h20;
            busy = 16;
        end
    endfunction

    function automatic void m_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            scr[m_row][m_col] = b;
            if (m_col == 15) m_newline();
            else m_col++;
        end else begin
            case (b)
                8'h0A: m_newline();
                8'h0D: m_col = 0;
                8'h08: if (m_col > 0) begin
                    m_col--;
                    scr[m_row][m_col] = 8'h20;
                end
                8'h0C: begin
                    m_clear();
                    busy = 128;
                end
                default: ;
            endcase
        end
    endfunction

    always @(negedge clk) begin
        if (prev_rst) begin
            chk("reset_rd_char", rd_char, 8'h20);
            chk("reset_ready", in_ready, 0);
            chk("reset_row", cur_row, 0);
            chk("reset_col", cur_col, 0);
        end
        if (rst) begin
            m_clear();
            busy = 128;
            have_exp = 0;
        end else begin
            if (have_exp) chk("rd_char", rd_char, exp_char);
            chk("in_ready", in_ready, (busy == 0) ? 1 : 0);
            if (in_ready && busy == 0) begin
                chk("cur_row", cur_row, m_row);
                chk("cur_col", cur_col, m_col);
            end
            have_exp = in_ready;
            exp_char = scr[rd_idx / 16][rd_idx % 16];
            if (busy > 0) busy--;
            if (in_valid && in_ready) m_byte(in_data);
        end
        prev_rst = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int c);
        c = 0;
        while (!in_ready && c < 400) begin
            tick();
            c++;
        end
        if (c >= 400) chk("ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [7:0] b);
        int c;
        wait_ready(c);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic rd(input int idx, output logic [7:0] v);
        rd_idx = 7'(idx);
        tick();
        v = rd_char;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic count_blank_cells(input string name);
        logic [7:0] v;
        int bad = 0;
        for (int i = 0; i < 128; i++) begin
            rd(i, v);
            if (v != 8'h20) bad++;
        end
        chk(name, bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int bad;
        logic [7:0] v;
        logic [7:0] b;
        int r;

        repeat (3) tick();
        rst = 1'b0;
        wait_ready(c);
        chk("init_ready_cycles", c, 128);
        count_blank_cells("init_blank");

        send(8'h48);
        send(8'h49);
        rd(0, v);  chk("hi_cell0", v, 8'h48);
        rd(1, v);  chk("hi_cell1", v, 8'h49);
        chk("hi_row", cur_row, 0);
        chk("hi_col", cur_col, 2);

        send(8'h0C);
        for (int i = 0; i < 16; i++) send(8'h41);
        send(8'h42);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            rd(i, v);
            if (v != 8'h41) bad++;
        end
        chk("wrap_row0", bad, 0);
        rd(16, v); chk("wrap_cell16", v, 8'h42);
        chk("wrap_row", cur_row, 1);
        chk("wrap_col", cur_col, 1);

        send(8'h0C);
        for (int row = 0; row < 8; row++) begin
            for (int i = 0; i < 8; i++) send(8'h61 + 8'(row));
            send(8'h0A);
        end
        wait_ready(c);
        chk("scroll_busy_cycles", c, 16);
        rd(0, v);       chk("scroll_row0", v, 8'h62);
        rd(6*16+3, v);  chk("scroll_row6", v, 8'h68);
        rd(7*16, v);    chk("scroll_row7", v, 8'h20);
        chk("scroll_cur_row", cur_row, 7);
        chk("scroll_cur_col", cur_col, 0);

        send(8'h08);
        chk("bs0_col", cur_col, 0);
        rd(7*16, v);    chk("bs0_cell", v, 8'h20);
        send(8'h58);
        send(8'h08);
        rd(7*16, v);    chk("bs_cell", v, 8'h20);
        chk("bs_col", cur_col, 0);

        send(8'h51);
        send(8'h0C);
        repeat (50) tick();
        do_reset();
        wait_ready(c);
        chk("midclear_ready_cycles", c, 128);
        count_blank_cells("midclear_blank");
        chk("midclear_row", cur_row, 0);
        chk("midclear_col", cur_col, 0);

        for (int n = 0; n < 1500; n++) begin
            rd_idx = 7'($urandom);
            if ($urandom_range(0, 3) == 0) tick();
            r = $urandom_range(0, 99);
            if (r < 70)      b = 8'($urandom_range(8'h20, 8'h7E));
            else if (r < 80) b = 8'h0A;
            else if (r < 85) b = 8'h0D;
            else if (r < 93) b = 8'h08;
            else if (r < 94) b = 8'h0C;
            else             b = 8'($urandom_range(0, 31));
            send(b);
        end
        wait_ready(c);
        for (int i = 0; i < 128; i++) begin
            rd_idx = 7'(i);
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
